mult4_arbiter: RTL
==================

MULT4_ARBITER -- requirements
Module: mult4_arbiter

Interface
REQ-001 SHALL have parameter STAT_W, default 16, meaning the width of each per-port completion counter (used only under MULT4_ARBITER_STATS_EN).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req_valid0/req_valid1, input, 1 each, meaning the requester presents operands.
REQ-005 SHALL have ports req_ready0/req_ready1, output, 1 each, meaning the operands are accepted this cycle.
REQ-006 SHALL have ports a0/b0/a1/b1, input, 4 each, meaning the unsigned operands of each requester.
REQ-007 SHALL have ports resp_valid0/resp_valid1, output, 1 each, meaning the product for that requester is on product.
REQ-008 SHALL have ports resp_ready0/resp_ready1, input, 1 each, meaning the requester takes the product.
REQ-009 SHALL have port product, output, 8, meaning the registered unsigned product, shared by both requesters.
REQ-010 SHALL, under MULT4_ARBITER_STATS_EN only, have ports done_cnt0/done_cnt1, output, STAT_W each, meaning completed transactions per port.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, RESP; one shared 4x4 multiplier, one transaction in flight.
REQ-012 SHALL, in IDLE, grant one valid requester: a single valid requester wins; with both valid, the port not marked by the priority pointer wins (pointer = last served port).
REQ-013 SHALL assert req_readyN combinationally only in IDLE and only for the granted port; never both in one cycle.
REQ-014 SHALL, on handshake (req_validN and req_readyN), latch aN/bN and the grant index, then enter CALC.
REQ-015 SHALL, in CALC, register the full 8-bit product of the latched operands (no truncation, 15*15=225), then enter RESP.
REQ-016 SHALL, in RESP, hold resp_validN high for the granted port only, with product stable, until resp_readyN is high.
REQ-017 SHALL, on the response handshake, set the priority pointer to the served port and return to IDLE; accept latency is 2 cycles, minimum request-to-request spacing 3 cycles.
REQ-018 SHALL ignore resp_ready of the non-granted port and req_valid of either port outside IDLE.
REQ-019 SHALL hold product at its last value after the response handshake until the next CALC.
REQ-020 SHALL not require req_valid to stay high after the handshake; dropping req_valid before the handshake withdraws the request without effect.

Reset
REQ-021 SHALL, on rst_n low, asynchronously force state IDLE, priority pointer to port 1 (port 0 wins the first tie), product 8'h00, both resp_valid 0, both req_ready 0 while in reset.
REQ-022 SHALL, on reset during CALC or RESP, discard the in-flight transaction with no response issued.

Configuration
REQ-023 SHALL, with MULT4_ARBITER_STATS_EN defined, increment done_cntN on each response handshake of port N, saturating at all-ones, reset to 0.
REQ-024 SHALL, without MULT4_ARBITER_STATS_EN, omit the counters and done_cnt ports entirely; all other behaviour identical.

Structure
REQ-025 SHALL place the state encoding (IDLE/CALC/RESP), OPERAND_W=4 and PRODUCT_W=8 in a shared package mult4_pkg.
REQ-026 SHALL instantiate the existing gate-level array_multiplier as its single sub-module for the multiply; no behavioural '*'.

Verification
REQ-027 SHALL cover: reset, port0 a=4'd7 b=4'd9 -> req_ready0 same cycle, resp_valid0 two cycles later, product=8'd63.
REQ-028 SHALL cover: a=4'hF b=4'hF on port1 -> product=8'd225 (8'hE1), resp_valid1 only.
REQ-029 SHALL cover: both ports valid continuously after reset -> grants alternate 0,1,0,1; each response carries its own port's product.
REQ-030 SHALL cover: resp_ready0 held low 5 cycles -> resp_valid0 and product stable 5 cycles, req_ready both 0 throughout.
REQ-031 SHALL cover: rst_n pulsed low in CALC -> outputs return to reset values immediately, no resp_valid afterwards, next request served normally.
REQ-032 SHALL cover, with MULT4_ARBITER_STATS_EN and STAT_W=2: 5 port0 transactions -> done_cnt0 = 3 (saturated), done_cnt1 = 0.

Source files
------------

// File: rtl/mult4_pkg.sv
// Shared definitions for the mult4_arbiter block: operand/product widths and FSM encoding.
package mult4_pkg;

  localparam int unsigned OPERAND_W = 4;
  localparam int unsigned PRODUCT_W = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/array_multiplier.sv
// Unsigned OPERAND_W x OPERAND_W array multiplier built from AND partial products and
// ripple-carry full-adder rows. Purely combinational.
module array_multiplier
  import mult4_pkg::*;
(
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  output logic [PRODUCT_W-1:0] product_o
);

  localparam int unsigned W = OPERAND_W;

  // Each row adds one shifted partial product to the running upper sum; the low bit of
  // every row drops out as a final product bit.
  always_comb begin : p_array
    logic [W-1:0] acc;
    logic [W-1:0] pp;
    logic [W-1:0] sum;
    logic         carry;
    logic         half;
    product_o    = '0;
    pp           = a_i & {W{b_i[0]}};
    product_o[0] = pp[0];
    acc          = {1'b0, pp[W-1:1]};
    for (int i = 1; i < W; i++) begin
      pp    = a_i & {W{b_i[i]}};
      carry = 1'b0;
      for (int j = 0; j < W; j++) begin
        half   = acc[j] ^ pp[j];
        sum[j] = half ^ carry;
        carry  = (acc[j] & pp[j]) | (carry & half);
      end
      product_o[i] = sum[0];
      acc          = {carry, sum[W-1:1]};
    end
    product_o[PRODUCT_W-1:W] = acc;
  end

endmodule

// File: rtl/mult4_arbiter.sv
// Two-port round-robin front end to a single shared 4x4 multiplier, one transaction in
// flight. Optional per-port saturating completion counters are built when
// MULT4_ARBITER_STATS_EN is defined (adds the done_cnt0/done_cnt1 ports).
module mult4_arbiter
  import mult4_pkg::*;
#(
  parameter int unsigned STAT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid0,
  input  logic                 req_valid1,
  output logic                 req_ready0,
  output logic                 req_ready1,
  input  logic [OPERAND_W-1:0] a0,
  input  logic [OPERAND_W-1:0] b0,
  input  logic [OPERAND_W-1:0] a1,
  input  logic [OPERAND_W-1:0] b1,
  output logic                 resp_valid0,
  output logic                 resp_valid1,
  input  logic                 resp_ready0,
  input  logic                 resp_ready1,
  output logic [PRODUCT_W-1:0] product
`ifdef MULT4_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]    done_cnt0,
  output logic [STAT_W-1:0]    done_cnt1
`endif
);

  state_e               state_q, state_d;
  logic                 gnt_q, gnt_d;    // port owning the in-flight transaction
  logic                 prio_q, prio_d;  // last served port; the other one wins ties
  logic [OPERAND_W-1:0] a_q, a_d;
  logic [OPERAND_W-1:0] b_q, b_d;
  logic [PRODUCT_W-1:0] product_q, product_d;
  logic [PRODUCT_W-1:0] mult_out;
  logic                 grant_idx;
  logic                 req_hs;
  logic                 resp_hs;

  array_multiplier u_mult (
    .a_i       (a_q),
    .b_i       (b_q),
    .product_o (mult_out)
  );

  // Arbitration and handshake decode; ready is gated by rst_n so nothing is accepted in reset.
  always_comb begin
    grant_idx   = (req_valid0 && req_valid1) ? ~prio_q : req_valid1;
    req_ready0  = rst_n && (state_q == StIdle) && req_valid0 && !grant_idx;
    req_ready1  = rst_n && (state_q == StIdle) && req_valid1 && grant_idx;
    resp_valid0 = (state_q == StResp) && !gnt_q;
    resp_valid1 = (state_q == StResp) && gnt_q;
    req_hs      = req_ready0 || req_ready1;
    resp_hs     = (resp_valid0 && resp_ready0) || (resp_valid1 && resp_ready1);
  end

  // Next-state logic: capture operands on accept, register product in CALC, wait in RESP.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    a_d       = a_q;
    b_d       = b_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (req_hs) begin
          gnt_d   = grant_idx;
          a_d     = grant_idx ? a1 : a0;
          b_d     = grant_idx ? b1 : b0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        product_d = mult_out;
        state_d   = StResp;
      end
      StResp: begin
        if (resp_hs) begin
          prio_d  = gnt_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      gnt_q     <= 1'b0;
      prio_q    <= 1'b1;
      a_q       <= '0;
      b_q       <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      prio_q    <= prio_d;
      a_q       <= a_d;
      b_q       <= b_d;
      product_q <= product_d;
    end
  end

  assign product = product_q;

`ifdef MULT4_ARBITER_STATS_EN
  logic [STAT_W-1:0] done_cnt0_q, done_cnt0_d;
  logic [STAT_W-1:0] done_cnt1_q, done_cnt1_d;

  // Saturating completion counters, bumped on each response handshake.
  always_comb begin
    done_cnt0_d = done_cnt0_q;
    done_cnt1_d = done_cnt1_q;
    if (resp_valid0 && resp_ready0 && (done_cnt0_q != '1)) begin
      done_cnt0_d = done_cnt0_q + 1'b1;
    end
    if (resp_valid1 && resp_ready1 && (done_cnt1_q != '1)) begin
      done_cnt1_d = done_cnt1_q + 1'b1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt0_q <= '0;
      done_cnt1_q <= '0;
    end else begin
      done_cnt0_q <= done_cnt0_d;
      done_cnt1_q <= done_cnt1_d;
    end
  end

  assign done_cnt0 = done_cnt0_q;
  assign done_cnt1 = done_cnt1_q;
`else
  logic unused_stat_w;
  assign unused_stat_w = (STAT_W == 0);
`endif

endmodule
